// File: rtl/gpio_config_pkg.sv
// Shared definitions for the GPIO configuration serializer: pad mode words,
// the fabric config-done arming pattern and the transfer state encoding.
package gpio_config_pkg;

  localparam int          CONFIG_BITS_PER_IO_PAD = 12;
  localparam logic [47:0] CONFIG_DONE_SEQUENCE   = 48'hFEEDBADCA77E;

  localparam logic [11:0] GPIO_MODE_OUTPUT           = 12'h2C6;
  localparam logic [11:0] GPIO_MODE_INPUT            = 12'h4C1;
  localparam logic [11:0] GPIO_MODE_BIDIRECTIONAL    = 12'h006;
  localparam logic [11:0] GPIO_MODE_FORCE_ONE_OUTPUT = 12'hB86;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_e;

endpackage

// File: rtl/gpio_config_serializer_timer.sv
// Phase timer: counts clk cycles spent in the current serializer state and
// flags the last cycle of a CLK_DIV-long phase. Restarted on every state change.
module config_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tc_o
);

  localparam int             W    = $clog2(CLK_DIV + 1);
  localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Count up from zero after a restart and park on the terminal value.
  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == LAST);

endmodule

// File: rtl/gpio_config_serializer.sv
// GPIO configuration serializer: once the fabric presents the config-done
// word, snapshots all pad mode words and shifts them MSB-first (highest pad
// first) into the pad-control chain, then pulses the chain load strobe.
module gpio_config_serializer
  import gpio_config_pkg::*;
#(
  parameter int          NUM_PADS      = 12,
  parameter int          BITS_PER_PAD  = CONFIG_BITS_PER_IO_PAD,
  parameter int          CLK_DIV       = 4,
  parameter logic [47:0] DONE_SEQUENCE = CONFIG_DONE_SEQUENCE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PADS*BITS_PER_PAD-1:0] mode_words,
  input  logic [47:0]                      done_word,
  input  logic                             reload,
  output logic                             serial_clock,
  output logic                             serial_data,
  output logic                             serial_load,
  output logic                             busy,
  output logic                             done
);

  localparam int            N        = NUM_PADS * BITS_PER_PAD;
  localparam int            BW       = $clog2(N + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  state_e        state_q, state_d;
  logic          match, match_q;
  logic          start;
  logic          phase_tc;
  logic          state_change;
  logic          last_bit;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          sclk_q, sclk_d;
  logic          sdata_q, sdata_d;
  logic          sload_q, sload_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  assign match        = (done_word == DONE_SEQUENCE);
  assign start        = ((state_q == IDLE) || (state_q == DONE)) &&
                        ((match && !match_q) || (reload && match));
  assign last_bit     = (bit_cnt_q == LAST_BIT);
  assign state_change = (state_d != state_q);

  config_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk       (clk),
    .rst       (rst),
    .restart_i (state_change),
    .tc_o      (phase_tc)
  );

  // Next-state logic; output registers are derived from the next state so
  // every output changes on the same edge as the state it reflects.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    sdata_d   = sdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SHIFT_LO;
          shadow_d  = mode_words;
          bit_cnt_d = '0;
          sdata_d   = mode_words[N-1];
        end
      end
      SHIFT_LO: begin
        if (phase_tc) begin
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (phase_tc) begin
          if (last_bit) begin
            state_d = LOAD;
          end else begin
            state_d   = SHIFT_LO;
            bit_cnt_d = bit_cnt_q + 1'b1;
            shadow_d  = {shadow_q[N-2:0], shadow_q[N-1]};
            sdata_d   = shadow_q[N-2];
          end
        end
      end
      LOAD: begin
        if (phase_tc) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    sclk_d  = (state_d == SHIFT_HI);
    sload_d = (state_d == LOAD);
    busy_d  = (state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == LOAD);
    done_d  = (state_d == DONE);
  end

  // State, snapshot, counter, arming edge detector and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      match_q   <= 1'b0;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      sload_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      sload_q   <= sload_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign serial_clock = sclk_q;
  assign serial_data  = sdata_q;
  assign serial_load  = sload_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
